// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register skid buffer: state encoding
// and default payload field widths.
package pipe_pkg;

  localparam int unsigned OPW_DEF  = 5;
  localparam int unsigned RDW_DEF  = 9;
  localparam int unsigned BRW_DEF  = 7;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned CNTW_DEF = 16;

  // EMPTY: nothing held; MAIN: output register full; SKID: output and skid full
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    SKID  = 2'd2
  } skid_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_reg_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            inc,
  output logic [CNTW-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNTW{1'b1}})) begin
      count <= count + CNTW'(1);
    end
  end

endmodule : sat_counter

// File: rtl/pipe_reg_skid.sv
// Two-entry skid-buffered pipeline register. in_ready is a flop, so the
// upstream ready path is fully decoupled from out_ready.
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int unsigned OPW  = OPW_DEF,
  parameter int unsigned RDW  = RDW_DEF,
  parameter int unsigned BRW  = BRW_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  OpCode,
  input  logic [RDW-1:0]  RdOut,
  input  logic [BRW-1:0]  BranchResult,
  input  logic [DW-1:0]   AluResult,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  OpCodeOut,
  output logic [RDW-1:0]  RdOutOut,
  output logic [BRW-1:0]  BranchResultOutOut,
  output logic [DW-1:0]   AluResultOut,
  output logic [CNTW-1:0] stall_cnt
);

  skid_state_t    state;

  logic [OPW-1:0] skid_op;
  logic [RDW-1:0] skid_rd;
  logic [BRW-1:0] skid_br;
  logic [DW-1:0]  skid_alu;

  logic in_xfer_c;
  logic out_xfer_c;
  logic stall_inc_c;

  always_comb begin
    in_xfer_c   = in_valid & in_ready;
    out_xfer_c  = out_valid & out_ready;
    // A flush cycle leaves the stall count untouched
    stall_inc_c = out_valid & ~out_ready & ~flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= EMPTY;
      out_valid          <= 1'b0;
      in_ready           <= 1'b1;
      OpCodeOut          <= '0;
      RdOutOut           <= '0;
      BranchResultOutOut <= '0;
      AluResultOut       <= '0;
      skid_op            <= '0;
      skid_rd            <= '0;
      skid_br            <= '0;
      skid_alu           <= '0;
    end else if (flush) begin
      // Drop every held entry; payload registers keep stale contents
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer_c) begin
            OpCodeOut          <= OpCode;
            RdOutOut           <= RdOut;
            BranchResultOutOut <= BranchResult;
            AluResultOut       <= AluResult;
            state              <= MAIN;
            out_valid          <= 1'b1;
            in_ready           <= 1'b1;
          end
        end
        MAIN: begin
          if (in_xfer_c && out_xfer_c) begin
            OpCodeOut          <= OpCode;
            RdOutOut           <= RdOut;
            BranchResultOutOut <= BranchResult;
            AluResultOut       <= AluResult;
          end else if (in_xfer_c) begin
            skid_op   <= OpCode;
            skid_rd   <= RdOut;
            skid_br   <= BranchResult;
            skid_alu  <= AluResult;
            state     <= SKID;
            in_ready  <= 1'b0;
          end else if (out_xfer_c) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        SKID: begin
          // in_ready is low here, so only an output transfer can occur
          if (out_xfer_c) begin
            OpCodeOut          <= skid_op;
            RdOutOut           <= skid_rd;
            BranchResultOutOut <= skid_br;
            AluResultOut       <= skid_alu;
            state              <= MAIN;
            in_ready           <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(
    .CNTW (CNTW)
  ) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_inc_c),
    .count (stall_cnt)
  );

endmodule : pipe_reg_skid

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid: a queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_pipe_reg_skid;

  localparam int unsigned T_OPW  = 5;
  localparam int unsigned T_RDW  = 5;
  localparam int unsigned T_BRW  = 7;
  localparam int unsigned T_DW   = 64;
  localparam int unsigned T_CNTW = 4;
  localparam int          CNT_MAX = (1 << T_CNTW) - 1;

  typedef struct {
    logic [T_OPW-1:0] op;
    logic [T_RDW-1:0] rd;
    logic [T_BRW-1:0] br;
    logic [T_DW-1:0]  alu;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [T_OPW-1:0]  op_in = '0;
  logic [T_RDW-1:0]  rd_in = '0;
  logic [T_BRW-1:0]  br_in = '0;
  logic [T_DW-1:0]   alu_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [T_OPW-1:0]  op_out;
  logic [T_RDW-1:0]  rd_out;
  logic [T_BRW-1:0]  br_out;
  logic [T_DW-1:0]   alu_out;
  logic [T_CNTW-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  pipe_reg_skid #(
    .OPW (T_OPW), .RDW (T_RDW), .BRW (T_BRW), .DW (T_DW), .CNTW (T_CNTW)
  ) u_dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .OpCode             (op_in),
    .RdOut              (rd_in),
    .BranchResult       (br_in),
    .AluResult          (alu_in),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .OpCodeOut          (op_out),
    .RdOutOut           (rd_out),
    .BranchResultOutOut (br_out),
    .AluResultOut       (alu_out),
    .stall_cnt          (stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two held entries
  ent_t q[$];
  ent_t last;
  int   m_cnt;
  bit   m_ov, m_ir, m_ix, m_ox;
  ent_t cur;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      last  = '{default: '0};
      m_cnt = 0;
    end else begin
      m_ov = (q.size() > 0);
      m_ir = (q.size() < 2);
      m_ox = m_ov && out_ready;
      m_ix = m_ir && in_valid;
      cur  = '{op: op_in, rd: rd_in, br: br_in, alu: alu_in};
      if (m_ov && !out_ready && !flush && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (m_ox) void'(q.pop_front());
        if (m_ix) q.push_back(cur);
      end
      if (q.size() > 0) last = q[0];
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      check("op_out", 64'(op_out), 64'(last.op));
      check("rd_out", 64'(rd_out), 64'(last.rd));
      check("br_out", 64'(br_out), 64'(last.br));
      check("alu_out", alu_out, last.alu);
    end
  end

  task automatic send(input logic v, input logic [T_OPW-1:0] op, input logic [T_DW-1:0] alu);
    in_valid = v;
    op_in    = op;
    alu_in   = alu;
    rd_in    = T_RDW'(op + 5'd1);
    br_in    = T_BRW'(alu[6:0] ^ 7'h2A);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    started = 1'b1;
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_alu", alu_out, 64'd0);

    // Streaming with out_ready held high
    out_ready = 1'b1;
    send(1'b1, 5'd3, 64'd100);  tick();
    check("stream_op0", 64'(op_out), 64'd3);
    check("stream_v0", 64'(out_valid), 64'd1);
    send(1'b1, 5'd11, 64'd101); tick();
    check("stream_op1", 64'(op_out), 64'd11);
    check("stream_v1", 64'(out_valid), 64'd1);
    send(1'b1, 5'd7, 64'd102);  tick();
    check("stream_op2", 64'(op_out), 64'd7);
    check("stream_v2", 64'(out_valid), 64'd1);
    send(1'b0, 5'd0, 64'd0);    tick();
    check("stream_drain", 64'(out_valid), 64'd0);

    // Backpressure: A=2 then B=9 while stalled
    out_ready = 1'b0;
    send(1'b1, 5'd1, 64'd2);    tick();
    check("bp_a_out", alu_out, 64'd2);
    send(1'b1, 5'd2, 64'd9);    tick();
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_hold_a", alu_out, 64'd2);
    check("bp_stall1", 64'(stall_cnt), 64'd1);
    send(1'b0, 5'd0, 64'd0);
    out_ready = 1'b1;           tick();
    check("bp_b_out", alu_out, 64'd9);
    check("bp_b_valid", 64'(out_valid), 64'd1);
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush while in SKID with a same-cycle input
    out_ready = 1'b0;
    send(1'b1, 5'd4, 64'h11);   tick();
    send(1'b1, 5'd5, 64'h22);   tick();
    check("fl_skid", 64'(in_ready), 64'd0);
    flush = 1'b1;
    send(1'b1, 5'd6, 64'h33);   tick();
    flush = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    check("fl_stall", 64'(stall_cnt), 64'd2);
    check("fl_stale", alu_out, 64'h11);
    send(1'b0, 5'd0, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_ghost", 64'(out_valid), 64'd0);
    end

    // Flush in MAIN with an accepted-looking input
    send(1'b1, 5'd8, 64'h44);   tick();
    flush = 1'b1;
    send(1'b1, 5'd9, 64'h55);   tick();
    flush = 1'b0;
    send(1'b0, 5'd0, 64'd0);
    check("flm_valid", 64'(out_valid), 64'd0);
    tick();

    // Saturation from a clean counter
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    send(1'b1, 5'd10, 64'h66);  tick();
    send(1'b0, 5'd0, 64'd0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_15", 64'(stall_cnt), 64'd15);

    // Reset while in SKID
    send(1'b1, 5'd12, 64'h77);  tick();
    check("rs_skid", 64'(in_ready), 64'd0);
    send(1'b0, 5'd0, 64'd0);
    rst = 1'b1;                 tick();
    rst = 1'b0;
    check("rs_valid", 64'(out_valid), 64'd0);
    check("rs_ready", 64'(in_ready), 64'd1);
    check("rs_stall", 64'(stall_cnt), 64'd0);
    check("rs_op", 64'(op_out), 64'd0);
    check("rs_alu", alu_out, 64'd0);
    out_ready = 1'b1;
    tick();
    check("rs_gone", 64'(out_valid), 64'd0);

    // Wide payload passes through untouched
    in_valid = 1'b1;
    op_in    = 5'd13;
    rd_in    = 5'h1F;
    br_in    = 7'h55;
    alu_in   = 64'hDEAD_BEEF_0000_0001;
    tick();
    in_valid = 1'b0;
    check("wide_alu", alu_out, 64'hDEAD_BEEF_0000_0001);
    check("wide_rd", 64'(rd_out), 64'h1F);
    check("wide_br", 64'(br_out), 64'h55);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pipe_reg_skid
